// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the LCD write arbiter.
// Contents:
//   state_t   - scheduler states (IDLE, ISSUE, GAP)
//   SRC_CPU   - source id of the processor character path
//   SRC_KEY   - source id of the keyboard echo path
//   DROP_MAX  - saturation value of the drop counter
package lcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_KEY = 1'b1;

    localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Bus bundle between the byte sources (processor, PS/2 echo) and the
// LCD write port, as seen by the arbiter.
// Signals:
//   cpu_we, cpu_data          processor write strobe and byte
//   key_pressed, key_data     PS/2 key-valid and scan byte
//   echo_en                   enables queuing of key bytes
//   lcd_write_en, lcd_write_data  one-cycle strobe and byte to the LCD
//   cpu_full                  processor FIFO full
//   drop_count                saturating count of dropped bytes
// Modports: master drives the source side, slave is the arbiter.
interface lcd_write_arbiter_if;

    logic       cpu_we;
    logic [7:0] cpu_data;
    logic       key_pressed;
    logic [7:0] key_data;
    logic       echo_en;
    logic       lcd_write_en;
    logic [7:0] lcd_write_data;
    logic       cpu_full;
    logic [7:0] drop_count;

    modport master (
        output cpu_we, cpu_data, key_pressed, key_data, echo_en,
        input  lcd_write_en, lcd_write_data, cpu_full, drop_count
    );

    modport slave (
        input  cpu_we, cpu_data, key_pressed, key_data, echo_en,
        output lcd_write_en, lcd_write_data, cpu_full, drop_count
    );

endinterface

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with show-ahead output.
// Ports:
//   i_clock, i_reset  clock and synchronous active-high reset
//   i_push, i_din     write request and byte (ignored when full)
//   i_pop             read request (ignored when empty)
//   o_dout            byte at the head of the queue
//   o_empty, o_full   decoded from the registered occupancy count
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    // Full/empty come from the count at the start of the cycle, so a push
    // into a full FIFO is refused even when a pop happens in the same cycle.
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers are log2(DEPTH) bits wide and wrap naturally.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the LCD controller write port between the processor character
// path and the PS/2 keyboard echo path. Each source has its own FIFO; a
// round-robin scheduler issues one-cycle write strobes separated by a
// programmable idle gap so the LCD controller can finish each character.
// Ports:
//   i_clock  system clock
//   i_reset  synchronous active-high reset
//   bus      slave side of lcd_write_arbiter_if (sources in, LCD out)
// Parameters:
//   FIFO_DEPTH  entries per source FIFO (power of two, >= 2)
//   GAP_CYCLES  idle cycles after each issued write (>= 1)
//
// State table:
//   IDLE  | wait for a non-empty FIFO; pop the granted source
//   ISSUE | drive the one-cycle strobe, load the gap counter
//   GAP   | count down the idle gap, return to IDLE at zero
module lcd_write_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    lcd_write_arbiter_if.slave bus
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [GW-1:0] r_gap_cnt;
    logic [7:0]    r_lcd_data;
    logic          r_last_grant;
    logic [7:0]    r_drop_count;

    logic          r_key_prev;
    logic          r_key_push;
    logic [7:0]    r_key_byte;

    logic          w_cpu_empty;
    logic          w_cpu_full;
    logic [7:0]    w_cpu_dout;
    logic          w_key_empty;
    logic          w_key_full;
    logic [7:0]    w_key_dout;

    logic          w_grant;
    logic          w_pop_cpu;
    logic          w_pop_key;
    logic          w_cpu_drop;
    logic          w_key_drop;
    logic [8:0]    w_drop_sum;

    // The key byte is registered along with the edge, which is what adds
    // the extra cycle of latency on the keyboard path.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_key_prev <= 1'b0;
            r_key_push <= 1'b0;
            r_key_byte <= 8'h00;
        end else begin
            r_key_prev <= bus.key_pressed;
            r_key_push <= bus.key_pressed && !r_key_prev && bus.echo_en;
            r_key_byte <= bus.key_data;
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_cpu_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (bus.cpu_we),
        .i_din   (bus.cpu_data),
        .i_pop   (w_pop_cpu),
        .o_dout  (w_cpu_dout),
        .o_empty (w_cpu_empty),
        .o_full  (w_cpu_full)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_key_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (r_key_push),
        .i_din   (r_key_byte),
        .i_pop   (w_pop_key),
        .o_dout  (w_key_dout),
        .o_empty (w_key_empty),
        .o_full  (w_key_full)
    );

    // On a tie the source not served last wins; a lone source always wins.
    always_comb begin
        w_grant = SRC_KEY;
        if (!w_cpu_empty && !w_key_empty) begin
            w_grant = (r_last_grant == SRC_KEY) ? SRC_CPU : SRC_KEY;
        end else if (!w_cpu_empty) begin
            w_grant = SRC_CPU;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop_cpu = 1'b0;
        w_pop_key = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_cpu_empty || !w_key_empty) begin
                    w_next = ISSUE;
                    if (w_grant == SRC_CPU) begin
                        w_pop_cpu = 1'b1;
                    end else begin
                        w_pop_key = 1'b1;
                    end
                end
            end
            ISSUE: begin
                w_next = GAP;
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_gap_cnt    <= '0;
            r_lcd_data   <= 8'h00;
            r_last_grant <= SRC_KEY;
        end else begin
            r_state <= w_next;
            if (r_state == ISSUE) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            if (w_pop_cpu) begin
                r_lcd_data   <= w_cpu_dout;
                r_last_grant <= SRC_CPU;
            end else if (w_pop_key) begin
                r_lcd_data   <= w_key_dout;
                r_last_grant <= SRC_KEY;
            end
        end
    end

    // Both sources can drop in the same cycle, so the sum is one bit wider
    // than the counter before it is clamped.
    assign w_cpu_drop = bus.cpu_we && w_cpu_full;
    assign w_key_drop = r_key_push && w_key_full;
    assign w_drop_sum = {1'b0, r_drop_count} + {8'h00, w_cpu_drop} + {8'h00, w_key_drop};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_drop_count <= 8'h00;
        end else if (w_cpu_drop || w_key_drop) begin
            r_drop_count <= (w_drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : w_drop_sum[7:0];
        end
    end

    assign bus.lcd_write_en   = (r_state == ISSUE);
    assign bus.lcd_write_data = r_lcd_data;
    assign bus.cpu_full       = w_cpu_full;
    assign bus.drop_count     = r_drop_count;

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single write port of the LCD controller between two requesters: the processor's character-write output and a keyboard echo path fed by the PS/2 interface. Each source is buffered in its own small FIFO. A round-robin scheduler issues one-cycle write strobes to the LCD controller, with a programmable idle gap between writes so the controller has time to complete each character. The block sits between processor/PS2_Interface and lcd in the top level, replacing the direct processor-to-lcd connection.

## Interface
- FIFO_DEPTH, 4: entries per source FIFO; power of two, minimum 2.
- GAP_CYCLES, 2000: idle cycles after each issued write (40 µs at 50 MHz); minimum 1.
- clock  in  1  system clock.
- reset  in  1  reset; **synchronous, active-high** (top level drives ~resetn).
- cpu_we  in  1  processor write strobe; one byte accepted per high cycle.
- cpu_data  in  8  processor character byte.
- key_pressed  in  1  PS/2 key-valid level/pulse; rising edge only is used.
- key_data  in  8  PS/2 scan byte.
- echo_en  in  1  when 1, key bytes are queued; when 0, they are ignored and not counted.
- lcd_write_en  out  1  one-cycle write strobe to the lcd controller.
- lcd_write_data  out  8  byte presented with lcd_write_en; held until the next issue.
- cpu_full  out  1  CPU FIFO full (combinational from the occupancy count).
- drop_count  out  8  bytes dropped from both sources combined; saturates at 255.

## Operation
- CPU push: cpu_we=1 and FIFO not full. Key push: rising edge of key_pressed (registered previous value) and echo_en=1 and FIFO not full.
- Full is evaluated at the start of the cycle. A push arriving when full is dropped, even if the same FIFO pops in that cycle. Each dropped byte increments drop_count by 1, saturating at 255. A CPU drop and a key drop in the same cycle add 2, still saturating.
- FSM states:
  - IDLE: if any FIFO is non-empty, select a source, pop it, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: lcd_write_en=1, lcd_write_data=popped byte; load gap counter with GAP_CYCLES-1; go to GAP.
  - GAP: decrement the counter; at 0, go to IDLE.
- Source selection:
  - If only one FIFO is non-empty, that source is granted.
  - If both are non-empty, grant the source not granted last. last_grant resets to KEY, so CPU wins the first tie.
- Per-FIFO ordering is FIFO. Pointers wrap modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- Reset at any point:
  - FIFOs emptied, FSM to IDLE, gap counter 0.
  - lcd_write_en=0, lcd_write_data=0, drop_count=0.
  - key edge register=0, last_grant=KEY.
  - Any in-flight byte is discarded.
- Reset values of outputs: lcd_write_en 0, lcd_write_data 8'h00, cpu_full 0, drop_count 0.

## Timing
- Latency: with the FSM idle and the FIFO empty, a push on cycle t gives lcd_write_en high on cycle t+2 (t+1 IDLE pops, t+2 ISSUE).
- A key byte adds one cycle for the edge detect: key_pressed rising sampled at t, push at t+1, strobe at t+3.
- Strobe spacing: for continuous traffic, lcd_write_en pulses are exactly GAP_CYCLES+2 cycles apart (ISSUE, GAP_CYCLES of GAP, IDLE).
- lcd_write_en is never high on two consecutive cycles.
- cpu_full reflects the registered count: it rises the cycle after the push that fills the FIFO and falls the cycle after a pop.

## Structure
- Package lcd_arb_pkg holds:
  - state enum {IDLE, ISSUE, GAP};
  - source id constants SRC_CPU=0, SRC_KEY=1;
  - DROP_MAX=8'hFF.
- Sub-module byte_fifo (parameter DEPTH; ports clock, reset, push, din[7:0], pop, dout[7:0], empty, full) is instantiated twice.
- The top holds the FSM, arbitration, gap counter, edge detect and drop counter.

## Test plan
All scenarios use GAP_CYCLES=4, FIFO_DEPTH=4.
- Single byte: reset, then cpu_we for one cycle with 8'h41 at t → lcd_write_en=1 with data 8'h41 at t+2 only; FSM in IDLE by t+8.
- Round-robin: pre-load CPU with 8'h10, 8'h11 and KEY with 8'hA0, 8'hA1 while the FSM is held in GAP → issue order 10, A0, 11, A1; pulses 6 cycles apart.
- Overflow: six back-to-back cpu_we (8'h01–8'h06) with the FSM busy → 01–04 issued, drop_count=2; cpu_full high until the first pop.
- Echo gating: key_pressed held high 5 cycles with echo_en=1 → exactly one byte queued. With echo_en=0 → none queued, drop_count unchanged.
- Saturation: 260 drops → drop_count=255 and stays there.
- Mid-operation reset: assert reset during GAP with 3 bytes queued → next cycle all outputs at reset values; no strobe afterward without a new push.
